// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals shared by the arbiter and its neighbours.
// No logic and no latency: the interface only carries wires.
// Flow control is valid/ready on the request and response channels; the ALU side has none.
interface alu_arbiter_if #(
    parameter int W = 4
);
    // requester 0 request channel
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [1:0]   req0_op;

    // requester 1 request channel
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [1:0]   req1_op;

    // response channels share one result bus, qualified per requester
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [W-1:0] rsp_result;

    // ALU datapath side
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [1:0]   alu_op;
    logic [W-1:0] alu_result;

    // arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result
    );

    // requester / ALU side
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer giving two requesters turns on one registered-output ALU.
// Latency: accept edge T0 -> response valid after edge T0+2; one operation every 4 cycles at best.
// Backpressure: ready only in IDLE; a held response (rsp ready low) stalls all new acceptance.
module alu_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]   state;
    logic         owner;
    logic         last_grant;
    logic         grant;
    logic         accept;
    logic         rsp_fire;

    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [1:0]   op_q;
    logic [W-1:0] result_q;
    logic         rsp0_q;
    logic         rsp1_q;

    // Pick the single valid requester, or the one that did not win last time when both ask.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // grant always points at a valid requester when any is valid, so acceptance is just "IDLE and someone asks"
    assign accept   = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign rsp_fire = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);

    assign bus.req0_ready = (state == IDLE) && !grant && bus.req0_valid;
    assign bus.req1_ready = (state == IDLE) &&  grant && bus.req1_valid;

    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_op     = op_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp0_valid = rsp0_q;
    assign bus.rsp1_valid = rsp1_q;

    assign busy = (state != IDLE);

    // Sequencer: accept, let the ALU sample, capture, then hold the response until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= grant;
                        state <= EXEC;
                    end
                end
                EXEC: state <= WAIT;
                WAIT: state <= RESP;
                RESP: begin
                    if (rsp_fire) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand registers load only on the acceptance edge and otherwise keep feeding the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (accept) begin
            a_q  <= grant ? bus.req1_a  : bus.req0_a;
            b_q  <= grant ? bus.req1_b  : bus.req0_b;
            op_q <= grant ? bus.req1_op : bus.req0_op;
        end
    end

    // Capture the ALU output one edge after it sampled the operands and flag the owner's response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
        end else if (state == WAIT) begin
            result_q <= bus.alu_result;
            rsp0_q   <= ~owner;
            rsp1_q   <= owner;
        end else if (rsp_fire) begin
            rsp0_q   <= 1'b0;
            rsp1_q   <= 1'b0;
        end
    end

    // Count completed response handshakes; wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
        end else if (rsp_fire) begin
            op_count <= op_count + 1'b1;
        end
    end
endmodule
